rrf_free_list: RTL and testbench

RRF_FREE_LIST -- requirements
Module: rrf_free_list

---
 rtl/rv32i_types.sv | 10 +
 rtl/rrf_free_list.sv | 79 +++++++
 tb/tb_rrf_free_list.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared core-wide types: physical register file sizing and free-list entry type.
package rv32i_types;

   localparam int NUM_PREGS      = 64;
   localparam int PREG_IDX_WIDTH = $clog2(NUM_PREGS);
   localparam int FL_DEPTH       = NUM_PREGS - 32;

   typedef logic [PREG_IDX_WIDTH-1:0] free_list_entry_t;

endpackage

// File: rtl/rrf_free_list.sv
// Retirement-side free list: a ring of free physical registers plus the committed
// arch-to-preg map. Commits recycle the previous mapping; a branch flush rewinds head.
module rrf_free_list #(
   parameter int NUM_PREGS = rv32i_types::NUM_PREGS,
   parameter int FL_DEPTH  = NUM_PREGS - 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_req,
   output rv32i_types::free_list_entry_t alloc_preg,
   output logic                         alloc_valid,
   input  logic                         commit_valid,
   input  logic [4:0]                   commit_rd,
   input  rv32i_types::free_list_entry_t commit_pd,
   input  logic                         branch_flush,
   output rv32i_types::free_list_entry_t areg_array_rrf [32],
   output logic [$clog2(FL_DEPTH):0]    free_count
);

   localparam int PTR_W  = $clog2(FL_DEPTH) + 1;
   localparam int IDX_W  = PTR_W - 1;
   localparam int PREG_W = rv32i_types::PREG_IDX_WIDTH;

   rv32i_types::free_list_entry_t ring [FL_DEPTH];
   rv32i_types::free_list_entry_t rrf_map [32];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] retire_head;
   logic [PTR_W-1:0] tail;

   logic             commit_en;
   logic             alloc_en;
   logic [PTR_W-1:0] retire_head_next;
   logic [PTR_W-1:0] tail_next;

   always_comb begin
      commit_en        = commit_valid && (commit_rd != 5'd0);
      alloc_en         = alloc_req && alloc_valid && !branch_flush;
      retire_head_next = commit_en ? retire_head + PTR_W'(1) : retire_head;
      tail_next        = commit_en ? tail + PTR_W'(1) : tail;
   end

   assign alloc_valid = (head != tail);
   assign alloc_preg  = ring[head[IDX_W-1:0]];
   assign free_count  = tail - head;

   for (genvar g = 0; g < 32; g++) begin : g_map_out
      assign areg_array_rrf[g] = rrf_map[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rrf_map[i] <= PREG_W'(i);
         end
         // Pregs above the 32 identity-mapped ones start out free.
         for (int i = 0; i < FL_DEPTH; i++) begin
            ring[i] <= PREG_W'(NUM_PREGS - FL_DEPTH + i);
         end
         head        <= '0;
         retire_head <= '0;
         tail        <= PTR_W'(FL_DEPTH);
      end else begin
         if (commit_en) begin
            rrf_map[commit_rd]     <= commit_pd;
            ring[tail[IDX_W-1:0]] <= rrf_map[commit_rd];
         end
         retire_head <= retire_head_next;
         tail        <= tail_next;
         // Flush rewinds to the post-commit retire point so this cycle's commit stays retired.
         if (branch_flush) begin
            head <= retire_head_next;
         end else if (alloc_en) begin
            head <= head + PTR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rrf_free_list.sv
// Self-checking bench for rrf_free_list: directed vectors, corner sequences and a
// queue-based reference model under random alloc/commit/flush/reset traffic.
module tb_rrf_free_list;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic [5:0] alloc_preg;
   logic       alloc_valid;
   logic       commit_valid;
   logic [4:0] commit_rd;
   logic [5:0] commit_pd;
   logic       branch_flush;
   logic [5:0] areg_array_rrf [32];
   logic [5:0] free_count;

   always #5 clk = ~clk;

   rrf_free_list dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_req      (alloc_req),
      .alloc_preg     (alloc_preg),
      .alloc_valid    (alloc_valid),
      .commit_valid   (commit_valid),
      .commit_rd      (commit_rd),
      .commit_pd      (commit_pd),
      .branch_flush   (branch_flush),
      .areg_array_rrf (areg_array_rrf),
      .free_count     (free_count)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: free pregs in allocation order, in-flight (dispatched, not
   // retired) pregs oldest first with their arch dest, and the committed map.
   int free_q[$];
   int infl_pd[$];
   int infl_rd[$];
   int map_m[32];

   typedef struct {
      logic       alloc;
      logic       cv;
      logic [4:0] rd;
      logic [5:0] pd;
      logic       fl;
      logic       ev;
      int         ep;
      int         ec;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic a, input logic cv, input logic [4:0] rd,
                      input logic [5:0] pd, input logic fl);
      rst          = r;
      alloc_req    = a;
      commit_valid = cv;
      commit_rd    = rd;
      commit_pd    = pd;
      branch_flush = fl;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      commit_rd    = '0;
      commit_pd    = '0;
      branch_flush = 1'b0;
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
   endtask

   task automatic check_identity(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) if (int'(areg_array_rrf[i]) != i) bad++;
      chk(name, bad, 0);
   endtask

   task automatic model_reset();
      free_q.delete();
      infl_pd.delete();
      infl_rd.delete();
      for (int i = 0; i < 32; i++) begin
         free_q.push_back(32 + i);
         map_m[i] = i;
      end
   endtask

   task automatic model_step(input bit a, input int ard, input bit cv, input int rd,
                             input int pd, input bit fl);
      int old;
      int merged[$];
      if (a && !fl && free_q.size() > 0) begin
         infl_pd.push_back(free_q.pop_front());
         infl_rd.push_back(ard);
      end
      if (cv && rd != 0) begin
         void'(infl_pd.pop_front());
         void'(infl_rd.pop_front());
         old       = map_m[rd];
         map_m[rd] = pd;
         free_q.push_back(old);
      end
      if (fl) begin
         merged = {infl_pd, free_q};
         free_q = merged;
         infl_pd.delete();
         infl_rd.delete();
      end
   endtask

   task automatic check_model();
      int bad;
      int distinct;
      bit seen[64];
      chk("rand_valid", int'(alloc_valid), (free_q.size() > 0) ? 1 : 0);
      if (free_q.size() > 0) chk("rand_preg", int'(alloc_preg), free_q[0]);
      chk("rand_count", int'(free_count), free_q.size());
      bad = 0;
      for (int i = 0; i < 32; i++) if (int'(areg_array_rrf[i]) != map_m[i]) bad++;
      chk("rand_map", bad, 0);
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      distinct = 0;
      for (int i = 0; i < 32; i++) begin
         if (!seen[areg_array_rrf[i]]) distinct++;
         seen[areg_array_rrf[i]] = 1'b1;
      end
      foreach (infl_pd[i]) begin
         if (!seen[infl_pd[i]]) distinct++;
         seen[infl_pd[i]] = 1'b1;
      end
      foreach (free_q[i]) begin
         if (!seen[free_q[i]]) distinct++;
         seen[free_q[i]] = 1'b1;
      end
      chk("rand_conserve", distinct + (32 + infl_pd.size() + free_q.size() - 64) * 100, 64);
   endtask

   initial begin
      rst          = 1'b0;
      alloc_req    = 1'b0;
      commit_valid = 1'b0;
      commit_rd    = '0;
      commit_pd    = '0;
      branch_flush = 1'b0;

      //            alloc cv  rd     pd      fl    ev    ep  ec
      vecs[0] = '{1'b0, 1'b1, 5'd0, 6'd40, 1'b0, 1'b1, 32, 32};
      vecs[1] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 33, 31};
      vecs[2] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 34, 30};
      vecs[3] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 35, 29};
      vecs[4] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 36, 28};
      vecs[5] = '{1'b0, 1'b1, 5'd7, 6'd32, 1'b0, 1'b1, 36, 29};
      vecs[6] = '{1'b0, 1'b0, 5'd0, 6'd0,  1'b1, 1'b1, 33, 32};
      vecs[7] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 34, 31};
      vecs[8] = '{1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 1'b1, 35, 30};

      // Reset state
      do_reset();
      chk("rst_count", int'(free_count), 32);
      chk("rst_preg", int'(alloc_preg), 32);
      chk("rst_valid", int'(alloc_valid), 1);
      chk("rst_map5", int'(areg_array_rrf[5]), 5);
      check_identity("rst_map");

      // x0 commit, allocs, commit, flush
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, vecs[i].alloc, vecs[i].cv, vecs[i].rd, vecs[i].pd, vecs[i].fl);
         chk($sformatf("vec%0d_valid", i), int'(alloc_valid), int'(vecs[i].ev));
         chk($sformatf("vec%0d_preg", i), int'(alloc_preg), vecs[i].ep);
         chk($sformatf("vec%0d_count", i), int'(free_count), vecs[i].ec);
         if (i == 0) chk("x0_map", int'(areg_array_rrf[0]), 0);
      end
      chk("flush_map7", int'(areg_array_rrf[7]), 32);
      for (int k = 0; k < 29; k++) begin
         chk("flush_seq", int'(alloc_preg), 35 + k);
         cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      end
      chk("flush_last_preg", int'(alloc_preg), 7);
      chk("flush_last_count", int'(free_count), 1);
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      chk("flush_drain_valid", int'(alloc_valid), 0);

      // Drain 32, then over-alloc, then commit into an empty ring
      do_reset();
      for (int k = 0; k < 32; k++) begin
         chk("drain_seq", int'(alloc_preg), 32 + k);
         cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      end
      chk("empty_valid", int'(alloc_valid), 0);
      chk("empty_count", int'(free_count), 0);
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      chk("over_valid", int'(alloc_valid), 0);
      chk("over_count", int'(free_count), 0);
      cyc(1'b0, 1'b1, 1'b1, 5'd3, 6'd32, 1'b0);
      chk("push_map3", int'(areg_array_rrf[3]), 32);
      chk("push_valid", int'(alloc_valid), 1);
      chk("push_preg", int'(alloc_preg), 3);
      chk("push_count", int'(free_count), 1);

      // Commit and flush in the same cycle
      do_reset();
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 5'd9, 6'd32, 1'b1);
      chk("cf_count", int'(free_count), 32);
      chk("cf_preg", int'(alloc_preg), 33);
      chk("cf_map9", int'(areg_array_rrf[9]), 32);

      // Reset mid-operation, overriding alloc/commit/flush
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 5'd12, 6'd33, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 5'd13, 6'd34, 1'b1);
      chk("midrst_count", int'(free_count), 32);
      chk("midrst_preg", int'(alloc_preg), 32);
      chk("midrst_valid", int'(alloc_valid), 1);
      check_identity("midrst_map");

      // Random traffic against the reference model
      model_reset();
      for (int n = 0; n < 10000; n++) begin
         bit r, a, cv, fl;
         int ard, rd, pd;
         r   = ($urandom_range(0, 999) < 2);
         a   = ($urandom_range(0, 9) < 6);
         ard = $urandom_range(1, 31);
         cv  = 1'b0;
         rd  = 0;
         pd  = 0;
         if (infl_pd.size() > 0 && $urandom_range(0, 9) < 4) begin
            cv = 1'b1;
            rd = infl_rd[0];
            pd = infl_pd[0];
         end else if ($urandom_range(0, 49) == 0) begin
            cv = 1'b1;
            rd = 0;
            pd = $urandom_range(0, 63);
         end
         fl = ($urandom_range(0, 19) == 0);
         cyc(r, a, cv, 5'(rd), 6'(pd), fl);
         if (r) model_reset();
         else   model_step(a, ard, cv, rd, pd, fl);
         check_model();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
